// File: rtl/config_pkg.sv
// Core-wide CSR address and data word types shared by CSR-side blocks.
package config_pkg;
  localparam int CsrAddrW = 12;
  localparam int WordW    = 32;

  typedef logic [CsrAddrW-1:0] CsrAddrT;
  typedef logic [WordW-1:0]    word;
endpackage

// File: rtl/csr_arb_pkg.sv
// Types for the CSR external-write arbiter.
package csr_arb_pkg;
  localparam int NumReqDef   = 4;
  localparam int MaxDeferDef = 4;

  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_t;

  typedef logic [$clog2(NumReqDef)-1:0] ReqIdxT;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Zero latency; grant_o is one-hot or zero, valid_o flags a grant.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic                 valid_o
);
  localparam int IdxW = $clog2(N);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IdxW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/csr_ext_arbiter.sv
// Shares the CSR external write port among NumReq one-entry slots, round-robin, one write/cycle.
// Accept-to-issue is 1 cycle minimum; writes colliding with the core's CSR access are deferred, then forced with a 1-cycle core stall.
module csr_ext_arbiter
  import config_pkg::*;
  import csr_arb_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int MaxDefer = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NumReq-1:0]                req_valid,
  output logic [NumReq-1:0]                req_ready,
  input  logic [NumReq-1:0][CsrAddrW-1:0]  req_addr,
  input  logic [NumReq-1:0][WordW-1:0]     req_data,
  input  logic                             core_csr_enable,
  input  logic [CsrAddrW-1:0]              core_csr_addr,
  output logic [CsrAddrW-1:0]              ext_addr,
  output logic [WordW-1:0]                 ext_data,
  output logic                             ext_write_enable,
  output logic                             core_stall,
  output logic                             busy
);
  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxDefer + 1);

  arb_state_t state_q, state_d;

  logic [NumReq-1:0]               pend_q, pend_d;
  logic [NumReq-1:0][CsrAddrW-1:0] addr_q;
  logic [NumReq-1:0][WordW-1:0]    data_q;
  logic [IdxW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]                 defer_q, defer_d;

  logic [NumReq-1:0] mask;
  logic [NumReq-1:0] mask_gnt, head_gnt, issue_sel, accept;
  logic              mask_vld, head_vld, head_masked;
  logic [IdxW-1:0]   win;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NumReq; i++) begin
      mask[i] = core_csr_enable && (addr_q[i] == core_csr_addr);
    end
  end

  rr_picker #(.N(NumReq)) u_pick_masked (
    .req_i   (pend_q & ~mask),
    .ptr_i   (rr_ptr_q),
    .grant_o (mask_gnt),
    .valid_o (mask_vld)
  );

  // Head ignores masks: it is the slot that accumulates deferrals and gets forced.
  rr_picker #(.N(NumReq)) u_pick_head (
    .req_i   (pend_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (head_gnt),
    .valid_o (head_vld)
  );

  assign head_masked = head_vld && |(head_gnt & mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    defer_d = defer_q;
    if (state_q == FORCE) begin
      state_d = ARB;
      defer_d = '0;
    end else if (head_masked) begin
      defer_d = defer_q + 1'b1;
      if (defer_q == CntW'(MaxDefer - 1)) begin
        state_d = FORCE;
      end
    end else begin
      defer_d = '0;
    end
  end

  always_comb begin
    core_stall = (state_q == FORCE);
    if (state_q == FORCE) begin
      issue_sel = head_gnt;
    end else begin
      issue_sel = mask_vld ? mask_gnt : '0;
    end
  end

  always_comb begin
    ext_addr = '0;
    ext_data = '0;
    win      = '0;
    for (int i = 0; i < NumReq; i++) begin
      ext_addr = ext_addr | (addr_q[i] & {CsrAddrW{issue_sel[i]}});
      ext_data = ext_data | (data_q[i] & {WordW{issue_sel[i]}});
      if (issue_sel[i]) begin
        win = IdxW'(i);
      end
    end
  end

  assign ext_write_enable = |issue_sel;
  assign busy             = |pend_q;

  // A slot draining this cycle can refill in the same cycle.
  assign req_ready = ~pend_q | issue_sel;
  assign accept    = req_valid & req_ready;
  assign pend_d    = (pend_q & ~issue_sel) | accept;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ext_write_enable) begin
      rr_ptr_d = (win == IdxW'(NumReq - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
      defer_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      defer_q  <= defer_d;
      for (int i = 0; i < NumReq; i++) begin
        if (accept[i]) begin
          addr_q[i] <= req_addr[i];
          data_q[i] <= req_data[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_csr_ext_arbiter.sv
// Directed bench for csr_ext_arbiter with a per-cycle reference model and literal trace checks.
module tb_csr_ext_arbiter;
  localparam int N    = 4;
  localparam int MAXD = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][11:0] req_addr;
  logic [N-1:0][31:0] req_data;
  logic              core_en;
  logic [11:0]       core_addr;
  logic [11:0]       ext_addr;
  logic [31:0]       ext_data;
  logic              ext_we;
  logic              core_stall;
  logic              busy;

  csr_ext_arbiter #(.NumReq(N), .MaxDefer(MAXD)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .core_csr_enable  (core_en),
    .core_csr_addr    (core_addr),
    .ext_addr         (ext_addr),
    .ext_data         (ext_data),
    .ext_write_enable (ext_we),
    .core_stall       (core_stall),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [11:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         trace[$];
  int          stall_log[$];
  logic [31:0] csr[int];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: slot contents, round-robin pointer, deferral count, force flag.
  bit          m_pend[N];
  logic [11:0] m_addr[N];
  logic [31:0] m_data[N];
  int          m_ptr;
  int          m_defer;
  bit          m_force;

  always @(negedge clk) begin : cmp
    int          iss;
    int          head;
    int          s;
    logic [N-1:0] erdy;
    logic [11:0] eaddr;
    logic [31:0] edata;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0; m_defer = 0; m_force = 0;
      chk($sformatf("rst_we@%0d", cyc), ext_we, 0);
      chk($sformatf("rst_addr@%0d", cyc), ext_addr, 0);
      chk($sformatf("rst_data@%0d", cyc), ext_data, 0);
      chk($sformatf("rst_stall@%0d", cyc), core_stall, 0);
      chk($sformatf("rst_busy@%0d", cyc), busy, 0);
      chk($sformatf("rst_ready@%0d", cyc), req_ready, 4'hF);
    end else begin
      iss = -1; head = -1;
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        if (head < 0 && m_pend[s]) head = s;
        if (iss < 0 && m_pend[s] && (m_force || !(core_en && m_addr[s] == core_addr))) iss = s;
      end
      erdy = '0;
      for (int i = 0; i < N; i++) erdy[i] = !m_pend[i] || (iss == i);
      eaddr = (iss >= 0) ? m_addr[iss] : 12'h0;
      edata = (iss >= 0) ? m_data[iss] : 32'h0;
      chk($sformatf("we@%0d", cyc), ext_we, (iss >= 0) ? 1 : 0);
      chk($sformatf("addr@%0d", cyc), ext_addr, eaddr);
      chk($sformatf("data@%0d", cyc), ext_data, edata);
      chk($sformatf("stall@%0d", cyc), core_stall, m_force ? 1 : 0);
      chk($sformatf("busy@%0d", cyc), busy, (m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3]) ? 1 : 0);
      chk($sformatf("ready@%0d", cyc), req_ready, erdy);

      if (m_force) begin
        m_force = 0; m_defer = 0;
      end else if (head >= 0 && core_en && m_addr[head] == core_addr) begin
        if (m_defer == MAXD - 1) m_force = 1;
        m_defer++;
      end else begin
        m_defer = 0;
      end
      if (iss >= 0) begin
        m_pend[iss] = 0;
        m_ptr = (iss + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && erdy[i]) begin
          m_pend[i] = 1; m_addr[i] = req_addr[i]; m_data[i] = req_data[i];
        end
      end
    end
    if (ext_we === 1'b1) begin
      trace.push_back('{cyc, ext_addr, ext_data});
      csr[int'(ext_addr)] = ext_data;
    end
    if (core_stall === 1'b1) stall_log.push_back(cyc);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    core_en = 1'b0; core_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Round-robin: four requests accepted together drain 0,1,2,3 back to back.
    trace.delete(); c = cyc;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_addr[i] = 12'h100 + 12'(i); req_data[i] = 32'h1000 + 32'(i);
    end
    tick(); req_valid = '0;
    repeat (6) tick();
    chk("rr_count", trace.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < trace.size()) begin
        chk($sformatf("rr_addr%0d", k), trace[k].a, 12'h100 + 12'(k));
        chk($sformatf("rr_cyc%0d", k), trace[k].cyc, c + 1 + k);
      end
    end

    // Conflict: slot1 deferred two cycles while slot2 goes around it.
    trace.delete(); c = cyc;
    req_valid = 4'b0110;
    req_addr[1] = 12'h305; req_data[1] = 32'h5555;
    req_addr[2] = 12'h340; req_data[2] = 32'h4040;
    tick(); req_valid = '0; core_en = 1'b1; core_addr = 12'h305;
    tick(); tick(); core_en = 1'b0;
    repeat (4) tick();
    chk("cf_count", trace.size(), 2);
    if (trace.size() == 2) begin
      chk("cf_first_addr", trace[0].a, 12'h340);
      chk("cf_first_cyc", trace[0].cyc, c + 1);
      chk("cf_second_addr", trace[1].a, 12'h305);
      chk("cf_second_cyc", trace[1].cyc, c + 3);
      chk("cf_second_data", trace[1].d, 32'h5555);
    end

    // Starvation: four deferrals, then one stalled cycle that forces the write.
    trace.delete(); stall_log.delete(); c = cyc;
    req_valid = 4'b0001; req_addr[0] = 12'h300; req_data[0] = 32'hCAFE;
    tick(); req_valid = '0; core_en = 1'b1; core_addr = 12'h300;
    repeat (6) tick(); core_en = 1'b0;
    repeat (3) tick();
    chk("sv_count", trace.size(), 1);
    if (trace.size() == 1) begin
      chk("sv_cyc", trace[0].cyc, c + 5);
      chk("sv_data", trace[0].d, 32'hCAFE);
    end
    chk("sv_stall_count", stall_log.size(), 1);
    if (stall_log.size() == 1) chk("sv_stall_cyc", stall_log[0], c + 5);

    // Back-to-back: sole requester streams one write per cycle.
    trace.delete(); c = cyc;
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b1000; req_addr[3] = 12'h3A0; req_data[3] = 32'hD0 + 32'(k);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("bb_count", trace.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < trace.size()) begin
        chk($sformatf("bb_data%0d", k), trace[k].d, 32'hD0 + 32'(k));
        chk($sformatf("bb_cyc%0d", k), trace[k].cyc, c + 1 + k);
      end
    end

    // Last writer: two slots hit the same CSR; round-robin order decides the survivor.
    trace.delete();
    req_valid = 4'b0011;
    req_addr[0] = 12'h344; req_data[0] = 32'hA;
    req_addr[1] = 12'h344; req_data[1] = 32'hB;
    tick(); req_valid = '0;
    repeat (4) tick();
    chk("lw_count", trace.size(), 2);
    if (trace.size() == 2) begin
      chk("lw_first", trace[0].d, 32'hA);
      chk("lw_second", trace[1].d, 32'hB);
    end
    chk("lw_csr", csr.exists(int'(12'h344)) ? csr[int'(12'h344)] : 32'hDEAD, 32'hB);

    // Reset mid-burst with three slots pending drops everything.
    trace.delete();
    req_valid = 4'b1110;
    req_addr[1] = 12'h111; req_addr[2] = 12'h222; req_addr[3] = 12'h333;
    tick(); req_valid = '0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", ext_we, 0);
    chk("mid_rst_ready", req_ready, 4'hF);
    tick(); rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_trace", trace.size(), 0);

    // Pointer restarts at 0 after reset: slot1 precedes slot3.
    trace.delete();
    req_valid = 4'b1010; req_addr[1] = 12'h3B1; req_addr[3] = 12'h3B3;
    tick(); req_valid = '0;
    repeat (4) tick();
    chk("ptr_rst_count", trace.size(), 2);
    if (trace.size() == 2) begin
      chk("ptr_rst_first", trace[0].a, 12'h3B1);
      chk("ptr_rst_second", trace[1].a, 12'h3B3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
